// File: rtl/lsu_split.sv
// ----------------------------------------------------------------------------
// lsu_split : load/store unit with DMEM, LED/switch MMIO and two-cycle
//             handling of half/word accesses that straddle a word boundary.
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lsu_split #(
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] LED_BASE   = 32'h1000_0000,
  parameter logic [31:0] SW_BASE    = 32'h1001_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [1:0]  i_mem_wren,
  input  logic [1:0]  i_data_type,
  input  logic        i_unsigned,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_ld_data,
  output logic        o_stall,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg
);

  localparam int          AW        = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [31:0] LEDG_ADDR = LED_BASE + 32'h0000_1000;
  localparam logic [29:0] LEDR_WA   = LED_BASE[31:2];
  localparam logic [29:0] LEDG_WA   = LEDG_ADDR[31:2];
  localparam logic [29:0] SW_WA     = SW_BASE[31:2];

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  state_t      state;
  logic [31:0] mem [DMEM_WORDS];
  logic [31:0] ledr_reg, ledg_reg, sw_meta, sw_sync, hold;

  logic        is_store, is_load, split_acc, in_split;
  logic        in_dmem, hit_ledr, hit_ledg, hit_sw;
  logic [2:0]  size;
  logic [1:0]  off;
  logic [29:0] wa;
  logic [7:0]  mask, be8;
  logic [63:0] st64, window, shifted;
  logic [3:0]  part_be;
  logic [31:0] part_wd, rdata, raw, ld_ext;

  always_comb begin
    is_store  = (i_mem_wren == 2'b01);
    is_load   = (i_mem_wren == 2'b10);
    off       = i_lsu_addr[1:0];
    case (i_data_type)
      2'b01:   begin size = 3'd2; mask = 8'h03; end
      2'b10:   begin size = 3'd1; mask = 8'h01; end
      default: begin size = 3'd4; mask = 8'h0F; end
    endcase
    split_acc = (is_store || is_load) && (({1'b0, off} + size) > 3'd4);
    in_split  = (state == SPLIT);
    // The second cycle of a split access targets the following word.
    wa        = i_lsu_addr[31:2] + {29'd0, in_split};
    be8       = mask << off;
    st64      = {32'd0, i_st_data} << {off, 3'b000};
    part_be   = in_split ? be8[7:4]    : be8[3:0];
    part_wd   = in_split ? st64[63:32] : st64[31:0];

    in_dmem   = (wa < 30'(DMEM_WORDS));
    hit_ledr  = (wa == LEDR_WA);
    hit_ledg  = (wa == LEDG_WA);
    hit_sw    = (wa == SW_WA);

    if (in_dmem)       rdata = mem[wa[AW-1:0]];
    else if (hit_ledr) rdata = ledr_reg;
    else if (hit_ledg) rdata = ledg_reg;
    else if (hit_sw)   rdata = sw_sync;
    else               rdata = 32'd0;

    window  = in_split ? {rdata, hold} : {32'd0, rdata};
    shifted = window >> {off, 3'b000};
    raw     = shifted[31:0];
    case (size)
      3'd1:    ld_ext = {{24{~i_unsigned & raw[7]}},  raw[7:0]};
      3'd2:    ld_ext = {{16{~i_unsigned & raw[15]}}, raw[15:0]};
      default: ld_ext = raw;
    endcase

    o_ld_data = (is_load && !i_reset) ? ld_ext : 32'd0;
    o_stall   = !i_reset && !in_split && split_acc;
  end

  // Data memory is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (is_store && !i_reset && in_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (part_be[b]) mem[wa[AW-1:0]][8*b +: 8] <= part_wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      ledr_reg <= 32'd0;
      ledg_reg <= 32'd0;
      sw_meta  <= 32'd0;
      sw_sync  <= 32'd0;
      hold     <= 32'd0;
    end else begin
      sw_meta <= i_io_sw;
      sw_sync <= sw_meta;
      case (state)
        IDLE: begin
          if (split_acc) state <= SPLIT;
          if (split_acc && is_load) hold <= rdata;
        end
        default: state <= IDLE;
      endcase
      if (is_store) begin
        for (int b = 0; b < 4; b++) begin
          if (part_be[b] && hit_ledr) ledr_reg[8*b +: 8] <= part_wd[8*b +: 8];
          if (part_be[b] && hit_ledg) ledg_reg[8*b +: 8] <= part_wd[8*b +: 8];
        end
      end
    end
  end

  assign o_io_ledr = ledr_reg;
  assign o_io_ledg = ledg_reg;

endmodule

`default_nettype wire

// File: tb/tb_lsu_split.sv
// ----------------------------------------------------------------------------
// tb_lsu_split : directed self-checking bench for lsu_split.
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lsu_split;

  localparam logic [1:0] ST = 2'b01, LD = 2'b10, NA = 2'b00;
  localparam logic [1:0] WD = 2'b00, HF = 2'b01, BY = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, st_data, io_sw;
  logic [1:0]  mem_wren, data_type;
  logic        uns;
  logic [31:0] ld_data, io_ledr, io_ledg;
  logic        stall;

  int checks = 0;
  int passes = 0;

  lsu_split dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_lsu_addr  (addr),
    .i_st_data   (st_data),
    .i_mem_wren  (mem_wren),
    .i_data_type (data_type),
    .i_unsigned  (uns),
    .i_io_sw     (io_sw),
    .o_ld_data   (ld_data),
    .o_stall     (stall),
    .o_io_ledr   (io_ledr),
    .o_io_ledg   (io_ledg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else passes++;
  endtask

  // New inputs appear 1 time unit after the edge; checks happen mid-cycle.
  task automatic drive(input logic [1:0] w, input logic [1:0] dt, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    mem_wren = w; data_type = dt; uns = u; addr = a; st_data = d;
    #4;
  endtask

  task automatic hold_cycle();
    @(posedge clk);
    #5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; io_sw = 32'd0;
    mem_wren = LD; data_type = WD; uns = 1'b0; addr = 32'h103; st_data = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ld",    ld_data, 32'd0);
    check("rst_ledr",  io_ledr, 32'd0);
    check("rst_ledg",  io_ledg, 32'd0);
    mem_wren = NA;
    rst = 1'b0;

    drive(ST, WD, 1'b0, 32'h100, 32'hDEADBEEF);
    check("stw_stall", {31'd0, stall}, 32'd0);
    drive(LD, BY, 1'b0, 32'h101, 32'd0);
    check("lb_s",      ld_data, 32'hFFFFFFBE);
    check("lb_stall",  {31'd0, stall}, 32'd0);
    drive(LD, BY, 1'b1, 32'h101, 32'd0);
    check("lb_u",      ld_data, 32'h000000BE);

    drive(ST, HF, 1'b0, 32'h102, 32'h00008001);
    drive(LD, HF, 1'b0, 32'h102, 32'd0);
    check("lh_s",      ld_data, 32'hFFFF8001);
    drive(LD, WD, 1'b0, 32'h100, 32'd0);
    check("lw_100",    ld_data, 32'h8001BEEF);

    drive(ST, WD, 1'b0, 32'h103, 32'h11223344);
    check("sst_stall1", {31'd0, stall}, 32'd1);
    hold_cycle();
    check("sst_stall2", {31'd0, stall}, 32'd0);
    drive(LD, BY, 1'b1, 32'h103, 32'd0);
    check("lb_103",    ld_data, 32'h00000044);
    drive(LD, WD, 1'b0, 32'h104, 32'd0);
    check("lw_104_lo", ld_data & 32'h00FFFFFF, 32'h00112233);
    drive(LD, HF, 1'b1, 32'h102, 32'd0);
    check("lhu_102",   ld_data, 32'h00004401);

    drive(LD, WD, 1'b0, 32'h103, 32'd0);
    check("sld_stall1", {31'd0, stall}, 32'd1);
    hold_cycle();
    check("sld_stall2", {31'd0, stall}, 32'd0);
    check("sld_data",   ld_data, 32'h11223344);

    drive(NA, WD, 1'b0, 32'h100, 32'hFFFFFFFF);
    check("na_ld",     ld_data, 32'd0);
    check("na_stall",  {31'd0, stall}, 32'd0);

    drive(ST, BY, 1'b0, 32'h1000_0001, 32'h0000005A);
    check("ledr_pre",  io_ledr, 32'd0);
    drive(NA, WD, 1'b0, 32'd0, 32'd0);
    check("ledr_sb",   io_ledr, 32'h00005A00);
    drive(ST, HF, 1'b0, 32'h1000_1002, 32'h0000ABCD);
    drive(LD, HF, 1'b1, 32'h1000_1002, 32'd0);
    check("ledg_sh",   io_ledg, 32'hABCD0000);
    check("ledg_lhu",  ld_data, 32'h0000ABCD);
    drive(LD, HF, 1'b0, 32'h1000_1002, 32'd0);
    check("ledg_lh",   ld_data, 32'hFFFFABCD);
    drive(LD, WD, 1'b0, 32'h1000_0000, 32'd0);
    check("ledr_lw",   ld_data, 32'h00005A00);

    drive(ST, WD, 1'b0, 32'h1001_0000, 32'hFFFFFFFF);
    drive(LD, WD, 1'b0, 32'h1001_0000, 32'd0);
    check("sw_st_ledr", io_ledr, 32'h00005A00);
    check("sw_st_ledg", io_ledg, 32'hABCD0000);
    check("sw_st_rd",   ld_data, 32'd0);

    drive(LD, WD, 1'b0, 32'h2000_0000, 32'd0);
    check("unmapped",  ld_data, 32'd0);

    @(posedge clk);
    #1;
    io_sw = 32'h0000_00F0;
    mem_wren = LD; data_type = WD; uns = 1'b0; addr = 32'h1001_0000;
    #4;
    check("sw_c0", ld_data, 32'd0);
    hold_cycle();
    check("sw_c1", ld_data, 32'd0);
    hold_cycle();
    check("sw_c2", ld_data, 32'h000000F0);

    drive(ST, WD, 1'b0, 32'h0, 32'h12345678);
    drive(ST, WD, 1'b0, 32'h1FFF, 32'hCAFEBABE);
    check("top_stall", {31'd0, stall}, 32'd1);
    hold_cycle();
    drive(LD, WD, 1'b0, 32'h0, 32'd0);
    check("wrap_w0",   ld_data, 32'h12345678);
    drive(LD, BY, 1'b1, 32'h1FFF, 32'd0);
    check("top_lb",    ld_data, 32'h000000BE);
    drive(LD, WD, 1'b0, 32'h1FFF, 32'd0);
    hold_cycle();
    check("top_sld",   ld_data, 32'h000000BE);

    drive(LD, WD, 1'b0, 32'h103, 32'd0);
    check("rsp_stall1", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #2;
    check("rsp_stall", {31'd0, stall}, 32'd0);
    check("rsp_ledr",  io_ledr, 32'd0);
    check("rsp_ledg",  io_ledg, 32'd0);
    check("rsp_ld",    ld_data, 32'd0);
    mem_wren = NA;
    #1;
    rst = 1'b0;
    drive(LD, WD, 1'b0, 32'h100, 32'd0);
    check("post_rst_lw",    ld_data, 32'h4401BEEF);
    check("post_rst_stall", {31'd0, stall}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_split.md
Name: lsu_split

Overview:
- Load-store unit that sits directly downstream of the decoder and consumes its `mem_wren`, `i_data_type` and `i_unsigned` outputs.
- Address comes from the ALU result; store data comes from rs2. Load data goes to the writeback mux as `wb_sel` source 2'b00.
- Contains word-organised data memory plus memory-mapped red/green LED output registers and a switch input port.
- Any half/word access that crosses a 32-bit word boundary is split into two cycles; a stall holds the PC during the first cycle.

Parameters:
- DMEM_WORDS, 2048, depth of data memory in 32-bit words (byte window 0x0000_0000 to 4*DMEM_WORDS-1).
- LED_BASE, 32'h1000_0000, LEDR register address; LEDG is at LED_BASE+0x1000.
- SW_BASE, 32'h1001_0000, switch input address.

Ports:
- i_clk  in  1  system clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_lsu_addr  in  32  byte address (ALU result)
- i_st_data  in  32  store data (rs2), bytes taken from the LSBs
- i_mem_wren  in  2  01 = store, 10 = load, 00/11 = no access
- i_data_type  in  2  00 word, 01 half, 10 byte, 11 treated as word
- i_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- i_io_sw  in  32  raw asynchronous switch inputs
- o_ld_data  out  32  load result, extended
- o_stall  out  1  1 = PC and pipeline inputs must hold this cycle
- o_io_ledr  out  32  LEDR register
- o_io_ledg  out  32  LEDG register

Behaviour:
- Reset (async, active-high):
  - state=IDLE; o_stall=0; o_io_ledr=0; o_io_ledg=0; SW synchroniser flops=0; split-holding register=0.
  - o_ld_data=0 while reset is asserted.
  - Memory contents are not reset.
- Region decode uses the word address: DMEM if addr < 4*DMEM_WORDS; LEDR/LEDG/SW if addr[31:2] matches the base's [31:2]. Anything else is unmapped.
- Access size: byte=1, half=2, word=4 bytes. The access is split iff (addr[1:0] + size) > 4. Bytes are little-endian.
- Loads:
  - Read is combinational within the cycle.
  - Byte/half result is sign- or zero-extended per i_unsigned; word ignores i_unsigned.
  - Unmapped addresses return 0.
  - SW returns the 2-flop-synchronised i_io_sw (2-cycle latency from pin).
  - LED addresses read back the register value.
- Stores:
  - Written on the rising edge with per-byte enables.
  - Unmapped addresses are ignored.
  - Stores to SW are ignored.
  - LED registers accept byte/half writes at the given lane.
- Non-access (i_mem_wren 00/11): no write; o_ld_data=0; o_stall=0.
- FSM IDLE:
  - Non-split access completes this cycle; o_stall=0.
  - Split access: o_stall=1 combinationally. Low part is performed on the word at addr[31:2] (store writes low bytes; load captures low bytes into the holding register). Next state = SPLIT.
- FSM SPLIT:
  - o_stall=0. High part uses word addr[31:2]+1.
  - Store writes the remaining bytes of i_st_data.
  - Load assembles holding-register bytes plus the new bytes, then extends.
  - Next state = IDLE unconditionally.
- Core holds all inputs stable while o_stall=1. If inputs change in SPLIT anyway, the high part uses the current inputs (no protection).
- Split access where either part is unmapped or crosses into an IO region: each part is evaluated independently (unmapped bytes read 0 / are dropped).
- Top DMEM word + 1 wraps to an unmapped address, not to word 0.
- Reset during SPLIT: returns to IDLE immediately. A low-half store already written stays written; a pending load is discarded.

Test Plan:
- Store word 0xDEADBEEF @0x100, then load byte @0x101 signed -> 0xFFFFFFBE; unsigned -> 0x000000BE; o_stall=0 throughout.
- Store half 0x8001 @0x102, load half signed @0x102 -> 0xFFFF8001; load word @0x100 -> 0x8001BEEF.
- Split store word 0x11223344 @0x103:
  - o_stall=1 for one cycle, then 0.
  - Load byte @0x103 -> 0x44; load word @0x104 -> 0xXX112233 pattern (low 3 bytes 0x112233).
  - Split load word @0x103 -> 0x11223344 after 2 cycles.
- Store byte 0x5A @LED_BASE+1 -> o_io_ledr=0x00005A00 next edge. Store word to SW_BASE -> no change anywhere.
- Drive i_io_sw=0x0000_00F0, load word @SW_BASE -> 0 for 2 cycles after the change, then 0xF0.
- Assert i_reset in SPLIT of a split load -> o_stall=0, state IDLE, LEDs 0; the next non-split load returns correct data.
